// File: rtl/mips_mc_pkg.sv
// Shared definitions for the MIPS multicycle controller: state encoding,
// opcode/funct values and ALU control codes.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALU operation class requested by the state machine
    localparam logic [1:0] ALUOP_ZERO  = 2'b00;
    localparam logic [1:0] ALUOP_ADD   = 2'b01;
    localparam logic [1:0] ALUOP_SUB   = 2'b10;
    localparam logic [1:0] ALUOP_FUNCT = 2'b11;

endpackage

// File: rtl/mips_mc_aludec.sv
// Combinational ALU decoder: maps ALU-op class and funct to alucontrol,
// and flags whether funct is a supported R-type operation.
module mips_mc_aludec
    import mips_mc_pkg::*;
(
    input  logic [5:0] funct,
    input  logic [1:0] aluop,
    output logic [2:0] alucontrol,
    output logic       funct_legal
);

    logic [2:0] funct_ctl;

    always_comb begin
        funct_legal = 1'b1;
        funct_ctl   = ALU_AND;
        case (funct)
            FN_ADD:  funct_ctl = ALU_ADD;
            FN_SUB:  funct_ctl = ALU_SUB;
            FN_AND:  funct_ctl = ALU_AND;
            FN_OR:   funct_ctl = ALU_OR;
            FN_SLT:  funct_ctl = ALU_SLT;
            default: funct_legal = 1'b0;
        endcase
    end

    always_comb begin
        alucontrol = ALU_AND;
        case (aluop)
            ALUOP_ADD:   alucontrol = ALU_ADD;
            ALUOP_SUB:   alucontrol = ALU_SUB;
            ALUOP_FUNCT: alucontrol = funct_ctl;
            default:     alucontrol = ALU_AND;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// Moore control FSM for the shared-memory multicycle MIPS datapath.
// Optional bne support is enabled by defining MIPS_MC_BNE_EN.
module mips_mc_controller
    import mips_mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcen,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] alucontrol,
    output logic [1:0] pcsrc,
    output logic       illegal,
    output logic [3:0] state
);

    state_t     state_reg;
    state_t     state_next;
    state_t     cur;
    logic       pcwrite;
    logic       branch;
    logic       branch_cond;
    logic [1:0] aluop;
    logic       funct_legal;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

`ifdef MIPS_MC_BNE_EN
    logic is_bne_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            is_bne_reg <= 1'b0;
        end else if (state_reg == DECODE) begin
            is_bne_reg <= (op == OP_BNE);
        end
    end

    assign branch_cond = is_bne_reg ? ~zero : zero;
`else
    assign branch_cond = zero;
`endif

    // Holding reset makes every output look like FETCH with enables gated off
    assign cur   = reset ? state_reg : FETCH;
    assign state = cur;
    assign pcen  = pcwrite | (branch & branch_cond);

    mips_mc_aludec u_aludec (
        .funct       (funct),
        .aluop       (aluop),
        .alucontrol  (alucontrol),
        .funct_legal (funct_legal)
    );

    always_comb begin
        state_next = cur;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        aluop      = ALUOP_ZERO;
        pcsrc      = 2'b00;
        illegal    = 1'b0;
        case (cur)
            FETCH: begin
                alusrcb = 2'b01;
                aluop   = ALUOP_ADD;
                irwrite = mem_ready & reset;
                pcwrite = mem_ready & reset;
                if (mem_ready) state_next = DECODE;
            end
            DECODE: begin
                alusrcb = 2'b11;
                aluop   = ALUOP_ADD;
                case (op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_RTYPE: begin
                        state_next = funct_legal ? EXECUTE : FETCH;
                        illegal    = ~funct_legal;
                    end
                    OP_BEQ:  state_next = BRANCH;
`ifdef MIPS_MC_BNE_EN
                    OP_BNE:  state_next = BRANCH;
`endif
                    OP_ADDI: state_next = ADDIEX;
                    OP_J:    state_next = JUMP;
                    default: begin
                        state_next = FETCH;
                        illegal    = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                aluop      = ALUOP_ADD;
                state_next = (op == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                iord = 1'b1;
                if (mem_ready) state_next = MEMWB;
            end
            MEMWB: begin
                memtoreg   = 1'b1;
                regwrite   = 1'b1;
                state_next = FETCH;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                if (mem_ready) state_next = FETCH;
            end
            EXECUTE: begin
                alusrca    = 1'b1;
                aluop      = ALUOP_FUNCT;
                state_next = ALUWB;
            end
            ALUWB: begin
                regdst     = 1'b1;
                regwrite   = 1'b1;
                state_next = FETCH;
            end
            BRANCH: begin
                alusrca    = 1'b1;
                aluop      = ALUOP_SUB;
                pcsrc      = 2'b01;
                branch     = 1'b1;
                state_next = FETCH;
            end
            ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                aluop      = ALUOP_ADD;
                state_next = ADDIWB;
            end
            ADDIWB: begin
                regwrite   = 1'b1;
                state_next = FETCH;
            end
            JUMP: begin
                pcsrc      = 2'b10;
                pcwrite    = 1'b1;
                state_next = FETCH;
            end
            default: state_next = FETCH;
        endcase
    end

endmodule

// File: tb/tb_mips_mc_controller.sv
// Randomized bench for mips_mc_controller: each instruction is expanded into
// its expected state path and per-state control values, then compared cycle by cycle.
module tb_mips_mc_controller;
    import mips_mc_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite;
    logic       alusrca, illegal;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mips_mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pcen       (pcen),
        .iord       (iord),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .alucontrol (alucontrol),
        .pcsrc      (pcsrc),
        .illegal    (illegal),
        .state      (state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b000;
        endcase
    endfunction

    function automatic logic funct_ok(input logic [5:0] f);
        return f == 6'b100000 || f == 6'b100010 || f == 6'b100100 ||
               f == 6'b100101 || f == 6'b101010;
    endfunction

    // Instruction class: 0 illegal, 1 lw, 2 sw, 3 R-type, 4 branch, 5 addi, 6 j
    function automatic int classify(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'b100011: return 1;
            6'b101011: return 2;
            6'b000000: return funct_ok(f) ? 3 : 0;
            6'b000100: return 4;
`ifdef MIPS_MC_BNE_EN
            6'b000101: return 4;
`endif
            6'b001000: return 5;
            6'b000010: return 6;
            default:   return 0;
        endcase
    endfunction

    // {iord, regdst, memtoreg, alusrca, alusrcb, pcsrc, alucontrol} per state
    function automatic logic [10:0] exp_mux(input state_t s, input logic [5:0] f);
        logic       e_iord = 1'b0, e_regdst = 1'b0, e_m2r = 1'b0, e_asa = 1'b0;
        logic [1:0] e_asb = 2'b00, e_psrc = 2'b00;
        logic [2:0] e_alu = 3'b000;
        case (s)
            FETCH:   begin e_asb = 2'b01; e_alu = 3'b010; end
            DECODE:  begin e_asb = 2'b11; e_alu = 3'b010; end
            MEMADR:  begin e_asa = 1'b1; e_asb = 2'b10; e_alu = 3'b010; end
            MEMRD:   e_iord = 1'b1;
            MEMWB:   e_m2r = 1'b1;
            MEMWR:   e_iord = 1'b1;
            EXECUTE: begin e_asa = 1'b1; e_alu = funct_alu(f); end
            ALUWB:   e_regdst = 1'b1;
            BRANCH:  begin e_asa = 1'b1; e_alu = 3'b110; e_psrc = 2'b01; end
            ADDIEX:  begin e_asa = 1'b1; e_asb = 2'b10; e_alu = 3'b010; end
            JUMP:    e_psrc = 2'b10;
            default: ;
        endcase
        return {e_iord, e_regdst, e_m2r, e_asa, e_asb, e_psrc, e_alu};
    endfunction

    function automatic logic [10:0] got_mux();
        return {iord, regdst, memtoreg, alusrca, alusrcb, pcsrc, alucontrol};
    endfunction

    int n_instr = 0;

    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                             input int fw, input int mw);
        state_t exp_st[$];
        logic   mr_q[$];
        int     c;
        logic   taken;
        logic   e_pcen, e_irw, e_mw, e_rw, e_ill;
        c = classify(o, f);
        taken = (o == 6'b000101) ? ~z : z;
        for (int k = 0; k < fw; k++) begin exp_st.push_back(FETCH); mr_q.push_back(1'b0); end
        exp_st.push_back(FETCH); mr_q.push_back(1'b1);
        exp_st.push_back(DECODE); mr_q.push_back(1'($urandom_range(0, 1)));
        case (c)
            1, 2: begin
                exp_st.push_back(MEMADR); mr_q.push_back(1'($urandom_range(0, 1)));
                for (int k = 0; k < mw; k++) begin
                    exp_st.push_back(c == 1 ? MEMRD : MEMWR); mr_q.push_back(1'b0);
                end
                exp_st.push_back(c == 1 ? MEMRD : MEMWR); mr_q.push_back(1'b1);
                if (c == 1) begin exp_st.push_back(MEMWB); mr_q.push_back(1'($urandom_range(0, 1))); end
            end
            3: begin
                exp_st.push_back(EXECUTE); mr_q.push_back(1'($urandom_range(0, 1)));
                exp_st.push_back(ALUWB);   mr_q.push_back(1'($urandom_range(0, 1)));
            end
            4: begin exp_st.push_back(BRANCH); mr_q.push_back(1'($urandom_range(0, 1))); end
            5: begin
                exp_st.push_back(ADDIEX); mr_q.push_back(1'($urandom_range(0, 1)));
                exp_st.push_back(ADDIWB); mr_q.push_back(1'($urandom_range(0, 1)));
            end
            6: begin exp_st.push_back(JUMP); mr_q.push_back(1'($urandom_range(0, 1))); end
            default: ;
        endcase
        for (int i = 0; i < exp_st.size(); i++) begin
            @(negedge clk);
            reset = 1'b1;
            op = o;
            funct = f;
            zero = z;
            mem_ready = mr_q[i];
            #1;
            e_pcen = (exp_st[i] == FETCH && mr_q[i]) || exp_st[i] == JUMP ||
                     (exp_st[i] == BRANCH && taken);
            e_irw  = exp_st[i] == FETCH && mr_q[i];
            e_mw   = exp_st[i] == MEMWR;
            e_rw   = exp_st[i] == MEMWB || exp_st[i] == ALUWB || exp_st[i] == ADDIWB;
            e_ill  = exp_st[i] == DECODE && c == 0;
            check("state", 32'(state), 32'(exp_st[i]));
            check("enables", 32'({pcen, irwrite, memwrite, regwrite, illegal}),
                  32'({e_pcen, e_irw, e_mw, e_rw, e_ill}));
            check("muxes", 32'(got_mux()), 32'(exp_mux(exp_st[i], f)));
        end
        n_instr++;
        $display("instr %0d op=%b funct=%b zero=%b fwait=%0d mwait=%0d cycles=%0d",
                 n_instr, o, f, z, fw, mw, exp_st.size());
    endtask

    task automatic check_reset_cycle(input string tag);
        #1;
        check({tag, "_state"}, 32'(state), 32'(FETCH));
        check({tag, "_enables"}, 32'({pcen, irwrite, memwrite, regwrite, illegal}), 32'd0);
        check({tag, "_muxes"}, 32'(got_mux()), 32'(exp_mux(FETCH, funct)));
    endtask

    logic [5:0] op_tbl [8] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                               6'b001000, 6'b000010, 6'b000101, 6'b111111};
    logic [5:0] fn_tbl [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    initial begin
        logic [5:0] o, f;
        reset = 1'b0;
        mem_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_reset_cycle("reset");
        end

        run_instr(6'b100011, 6'd0, 1'b0, 0, 0);       // lw
        run_instr(6'b101011, 6'd0, 1'b0, 0, 0);       // sw
        run_instr(6'b100011, 6'd0, 1'b1, 0, 3);       // lw with memory wait
        run_instr(6'b000100, 6'd0, 1'b1, 0, 0);       // beq taken
        run_instr(6'b000100, 6'd0, 1'b0, 0, 0);       // beq not taken
        run_instr(6'b000000, 6'b100101, 1'b0, 0, 0);  // or
        run_instr(6'b000000, 6'b000000, 1'b0, 0, 0);  // illegal funct
        run_instr(6'b000101, 6'd0, 1'b0, 0, 0);       // bne
        run_instr(6'b001000, 6'd0, 1'b0, 2, 0);       // addi with fetch wait
        run_instr(6'b000010, 6'd0, 1'b1, 0, 0);       // j

        // Reset asserted while a store is waiting on memory
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            op = 6'b101011;
            mem_ready = 1'b1;
        end
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check("mid_memwr_state", 32'(state), 32'(MEMWR));
        check("mid_memwr_we", 32'(memwrite), 32'd1);
        reset = 1'b0;
        #1;
        check_reset_cycle("midreset");
        @(negedge clk);
        check_reset_cycle("midreset_post");
        run_instr(6'b000000, 6'b100000, 1'b0, 1, 0);

        for (int n = 0; n < 150; n++) begin
            o = op_tbl[$urandom_range(0, 7)];
            if (o == 6'b111111) o = 6'($urandom_range(0, 63));
            f = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                            : fn_tbl[$urandom_range(0, 4)];
            run_instr(o, f, 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2)) : 0,
                      int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
